// File: rtl/blink_pkg.sv
// blink_pkg: shared definitions for the blink sequencer slice.
//   state_t          - sequencer FSM states (IDLE, ON, OFF, DONE)
//   DEF_COUNT_LENGTH - default width of the on/off duration fields
//   DEF_REP_LENGTH   - default width of the repeat-count field
package blink_pkg;

    localparam int DEF_COUNT_LENGTH = $clog2(6);
    localparam int DEF_REP_LENGTH   = 4;

    typedef enum logic [1:0] {
        IDLE,
        ON,
        OFF,
        DONE
    } state_t;

endpackage

// File: rtl/blink_timer.sv
// blink_timer: synchronous loadable down counter timing one blink phase.
//   i_clk     - clock, rising edge
//   i_rst     - synchronous active-high reset, clears the count
//   i_load    - load i_val into the counter (a value of 0 loads 1)
//   i_val     - phase duration in cycles
//   o_timeout - high in the cycle the count is 1, i.e. the last cycle of a
//               phase that was loaded with V (V cycles after the load edge)
module blink_timer #(
    parameter int W = 3
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    output logic         o_timeout
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] count_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= '0;
        end else if (i_load) begin
            count_q <= (i_val == '0) ? ONE : i_val;
        end else if (count_q != '0) begin
            // Runs down to 0 and parks there once a phase ends unreloaded.
            count_q <= count_q - ONE;
        end
    end

    assign o_timeout = (count_q == ONE);

endmodule

// File: rtl/blink_sequencer.sv
// blink_sequencer: drives an LED through a programmable number of ON/OFF
// pairs, with abort and a completion pulse.
//   i_clk       - clock, rising edge
//   i_rst       - synchronous active-high reset, highest priority
//   i_start     - one-cycle start request, honoured only in IDLE
//   i_stop      - abort request, sampled every cycle
//   i_on_time   - ON duration in cycles (0 treated as 1), latched at start
//   i_off_time  - OFF duration in cycles (0 treated as 1), latched at start
//   i_repeat    - number of ON/OFF pairs (0 treated as 1), latched at start
//   o_led       - high only in ON
//   o_busy      - high in ON and OFF
//   o_done      - one-cycle pulse on normal completion
module blink_sequencer
    import blink_pkg::*;
#(
    parameter int COUNT_LENGTH = DEF_COUNT_LENGTH,
    parameter int REP_LENGTH   = DEF_REP_LENGTH
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic                    i_stop,
    input  logic [COUNT_LENGTH-1:0] i_on_time,
    input  logic [COUNT_LENGTH-1:0] i_off_time,
    input  logic [REP_LENGTH-1:0]   i_repeat,
    output logic                    o_led,
    output logic                    o_busy,
    output logic                    o_done
);

    localparam logic [REP_LENGTH-1:0] REP_ONE = {{(REP_LENGTH-1){1'b0}}, 1'b1};

    state_t                  state_q;
    logic [COUNT_LENGTH-1:0] on_q;
    logic [COUNT_LENGTH-1:0] off_q;
    logic [REP_LENGTH-1:0]   rem_q;
    logic                    led_q;
    logic                    busy_q;
    logic                    done_q;

    logic                    tmr_load;
    logic [COUNT_LENGTH-1:0] tmr_val;
    logic                    tmr_timeout;

    // Timer reload happens on exactly the edges where the FSM enters ON or OFF.
    // The start cycle loads straight from the input since on_q is not yet valid.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = on_q;
        case (state_q)
            IDLE: begin
                if (i_start && !i_stop) begin
                    tmr_load = 1'b1;
                    tmr_val  = i_on_time;
                end
            end
            ON: begin
                if (!i_stop && tmr_timeout) begin
                    tmr_load = 1'b1;
                    tmr_val  = off_q;
                end
            end
            OFF: begin
                if (!i_stop && tmr_timeout && (rem_q > REP_ONE)) begin
                    tmr_load = 1'b1;
                    tmr_val  = on_q;
                end
            end
            default: begin
            end
        endcase
    end

    blink_timer #(
        .W(COUNT_LENGTH)
    ) u_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (tmr_load),
        .i_val    (tmr_val),
        .o_timeout(tmr_timeout)
    );

    // Outputs are registered alongside the state: each branch sets the
    // outputs that belong to the state being entered.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            on_q    <= '0;
            off_q   <= '0;
            rem_q   <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            led_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start && !i_stop) begin
                        on_q    <= i_on_time;
                        off_q   <= i_off_time;
                        rem_q   <= (i_repeat == '0) ? REP_ONE : i_repeat;
                        state_q <= ON;
                        led_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ON: begin
                    if (i_stop) begin
                        state_q <= IDLE;
                    end else if (tmr_timeout) begin
                        state_q <= OFF;
                        busy_q  <= 1'b1;
                    end else begin
                        led_q  <= 1'b1;
                        busy_q <= 1'b1;
                    end
                end
                OFF: begin
                    if (i_stop) begin
                        state_q <= IDLE;
                    end else if (tmr_timeout) begin
                        if (rem_q > REP_ONE) begin
                            rem_q   <= rem_q - REP_ONE;
                            state_q <= ON;
                            led_q   <= 1'b1;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        busy_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_led  = led_q;
    assign o_busy = busy_q;
    assign o_done = done_q;

endmodule

// File: tb/tb_blink_sequencer.sv
module tb_blink_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic [2:0] on_t;
    logic [2:0] off_t;
    logic [3:0] rep;
    logic       led;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic  led;
        logic  busy;
        logic  done;
        string nm;
    } exp_t;

    exp_t exp_q[$];

    typedef struct {
        logic       rst;
        logic       start;
        logic       stop;
        logic [2:0] on_t;
        logic [2:0] off_t;
        logic [3:0] rep;
        logic       led;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t tbl[13];

    blink_sequencer #(
        .COUNT_LENGTH(3),
        .REP_LENGTH  (4)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (start),
        .i_stop    (stop),
        .i_on_time (on_t),
        .i_off_time(off_t),
        .i_repeat  (rep),
        .o_led     (led),
        .o_busy    (busy),
        .o_done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Checker: one expectation per rising edge, compared just after the edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (led === e.led && busy === e.busy && done === e.done) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got led=%b busy=%b done=%b, expected led=%b busy=%b done=%b",
                         e.nm, led, busy, done, e.led, e.busy, e.done);
            end
        end
    end

    task automatic step(input logic r, input logic s, input logic p,
                        input logic [2:0] on_v, input logic [2:0] off_v,
                        input logic [3:0] rep_v,
                        input logic el, input logic eb, input logic ed,
                        input string nm);
        exp_t e;
        @(negedge clk);
        rst   = r;
        start = s;
        stop  = p;
        on_t  = on_v;
        off_t = off_v;
        rep   = rep_v;
        e.led  = el;
        e.busy = eb;
        e.done = ed;
        e.nm   = nm;
        exp_q.push_back(e);
    endtask

    // Idle cycles with scrambled config inputs, which must have no effect.
    task automatic idle(input int n, input logic el, input logic eb,
                        input logic ed, input string nm);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 1'b0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 4'($urandom_range(0, 15)), el, eb, ed, nm);
    endtask

    // Full uninterrupted run; expected waveform derived from the
    // zero-means-one rule and V-cycle phases.
    task automatic run_pattern(input int on_v, input int off_v, input int rep_v,
                               input string nm);
        int   eon;
        int   eoff;
        int   erep;
        logic first;
        eon   = (on_v == 0) ? 1 : on_v;
        eoff  = (off_v == 0) ? 1 : off_v;
        erep  = (rep_v == 0) ? 1 : rep_v;
        first = 1'b1;
        for (int p = 0; p < erep; p++) begin
            for (int c = 0; c < eon; c++) begin
                step(1'b0, first, 1'b0, 3'(on_v), 3'(off_v), 4'(rep_v),
                     1'b1, 1'b1, 1'b0, {nm, "_on"});
                first = 1'b0;
            end
            for (int c = 0; c < eoff; c++)
                step(1'b0, 1'b0, 1'b0, 3'(on_v), 3'(off_v), 4'(rep_v),
                     1'b0, 1'b1, 1'b0, {nm, "_off"});
        end
        step(1'b0, 1'b0, 1'b0, 3'(on_v), 3'(off_v), 4'(rep_v), 1'b0, 1'b0, 1'b1, {nm, "_done"});
        step(1'b0, 1'b0, 1'b0, 3'(on_v), 3'(off_v), 4'(rep_v), 1'b0, 1'b0, 1'b0, {nm, "_idle"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        on_t  = '0;
        off_t = '0;
        rep   = '0;

        // on=3 off=2 repeat=2 basic run, with junk config while running
        //            rst   start stop  on    off   rep    led   busy  done
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 4'd0,  1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 3'd3, 3'd2, 4'd2,  1'b1, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 3'd7, 3'd7, 4'd15, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 3'd1, 3'd1, 4'd1,  1'b1, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 3'd7, 3'd7, 4'd15, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 3'd7, 3'd7, 4'd15, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 4'd0,  1'b1, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 4'd0,  1'b1, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 3'd5, 3'd5, 4'd5,  1'b1, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 3'd5, 3'd5, 4'd5,  1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 3'd5, 3'd5, 4'd5,  1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 3'd5, 3'd5, 4'd5,  1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 3'd5, 3'd5, 4'd5,  1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 13; i++)
            step(tbl[i].rst, tbl[i].start, tbl[i].stop, tbl[i].on_t, tbl[i].off_t,
                 tbl[i].rep, tbl[i].led, tbl[i].busy, tbl[i].done,
                 $sformatf("tbl%0d", i));

        // all-zero config behaves as 1/1/1
        step(1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 4'd0, 1'b1, 1'b1, 1'b0, "zero_on");
        idle(1, 1'b0, 1'b1, 1'b0, "zero_off");
        idle(1, 1'b0, 1'b0, 1'b1, "zero_done");
        idle(1, 1'b0, 1'b0, 1'b0, "zero_idle");

        // stop in 3rd cycle of the 2nd ON phase
        step(1'b0, 1'b1, 1'b0, 3'd5, 3'd5, 4'd3, 1'b1, 1'b1, 1'b0, "stop_on1");
        idle(4, 1'b1, 1'b1, 1'b0, "stop_on1");
        idle(5, 1'b0, 1'b1, 1'b0, "stop_off1");
        idle(3, 1'b1, 1'b1, 1'b0, "stop_on2");
        step(1'b0, 1'b0, 1'b1, 3'd5, 3'd5, 4'd3, 1'b0, 1'b0, 1'b0, "stop_abort");
        idle(8, 1'b0, 1'b0, 1'b0, "stop_nodone");

        // restart attempt mid-sequence is ignored
        step(1'b0, 1'b1, 1'b0, 3'd4, 3'd2, 4'd1, 1'b1, 1'b1, 1'b0, "restart_on");
        step(1'b0, 1'b1, 1'b0, 3'd1, 3'd1, 4'd1, 1'b1, 1'b1, 1'b0, "restart_ign");
        idle(2, 1'b1, 1'b1, 1'b0, "restart_on");
        idle(2, 1'b0, 1'b1, 1'b0, "restart_off");
        // start in the DONE cycle is ignored too
        step(1'b0, 1'b1, 1'b0, 3'd3, 3'd3, 4'd3, 1'b0, 1'b0, 1'b1, "done_start");
        idle(2, 1'b0, 1'b0, 1'b0, "done_start_idle");

        // stop during OFF
        step(1'b0, 1'b1, 1'b0, 3'd1, 3'd3, 4'd2, 1'b1, 1'b1, 1'b0, "stopoff_on");
        idle(1, 1'b0, 1'b1, 1'b0, "stopoff_off");
        step(1'b0, 1'b0, 1'b1, 3'd1, 3'd3, 4'd2, 1'b0, 1'b0, 1'b0, "stopoff_abort");
        idle(5, 1'b0, 1'b0, 1'b0, "stopoff_idle");

        // reset during OFF of a repeat=4 run, reset beats start, then full rerun
        step(1'b0, 1'b1, 1'b0, 3'd2, 3'd3, 4'd4, 1'b1, 1'b1, 1'b0, "rst_on");
        idle(1, 1'b1, 1'b1, 1'b0, "rst_on");
        idle(1, 1'b0, 1'b1, 1'b0, "rst_off");
        step(1'b1, 1'b0, 1'b0, 3'd2, 3'd3, 4'd4, 1'b0, 1'b0, 1'b0, "rst_mid");
        step(1'b1, 1'b1, 1'b0, 3'd2, 3'd3, 4'd4, 1'b0, 1'b0, 1'b0, "rst_vs_start");
        run_pattern(2, 3, 4, "rst_rerun");

        // start and stop together in IDLE
        step(1'b0, 1'b1, 1'b1, 3'd3, 3'd3, 4'd3, 1'b0, 1'b0, 1'b0, "startstop");
        idle(3, 1'b0, 1'b0, 1'b0, "startstop_idle");

        // boundary and random configs
        run_pattern(7, 1, 1, "max_on");
        run_pattern(1, 7, 2, "max_off");
        for (int i = 0; i < 4; i++)
            run_pattern($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 4),
                        $sformatf("rand%0d", i));

        @(posedge clk);
        #3;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/blink_sequencer.md
BLINK_SEQUENCER -- requirements
Module: blink_sequencer

Interface
REQ-001 Parameter: COUNT_LENGTH, default $clog2(6), width of on/off duration fields.
REQ-002 Parameter: REP_LENGTH, default 4, width of repeat-count field.
REQ-003 i_clk  input  1  single clock; all logic on rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_start  input  1  one-cycle request to begin a blink sequence.
REQ-006 i_stop  input  1  abort request, level-sampled each cycle.
REQ-007 i_on_time  input  COUNT_LENGTH  ON-phase duration in cycles.
REQ-008 i_off_time  input  COUNT_LENGTH  OFF-phase duration in cycles.
REQ-009 i_repeat  input  REP_LENGTH  number of ON/OFF pairs.
REQ-010 o_led  output  1  blink output, 1 only in ON state.
REQ-011 o_busy  output  1  high in ON and OFF states.
REQ-012 o_done  output  1  one-cycle pulse on normal completion.

Function
REQ-013 FSM states SHALL be IDLE, ON, OFF, DONE; all outputs registered.
REQ-014 In IDLE, i_start=1 and i_stop=0 SHALL latch i_on_time, i_off_time, i_repeat, load the timer with the ON duration, and enter ON next cycle.
REQ-015 Duration value 0 SHALL be treated as 1; i_repeat=0 SHALL be treated as 1.
REQ-016 Each phase with duration V SHALL last exactly V cycles (o_led high for exactly V_on cycles per pair).
REQ-017 ON timeout SHALL enter OFF and load timer with latched OFF duration.
REQ-018 OFF timeout with remaining pairs >1 SHALL decrement remaining count, enter ON, reload ON duration; with remaining =1 SHALL enter DONE.
REQ-019 DONE SHALL last one cycle with o_done=1, o_led=0, o_busy=0, then return to IDLE.
REQ-020 i_start while not IDLE SHALL be ignored; config inputs SHALL be ignored outside the IDLE start cycle.
REQ-021 i_stop=1 in ON or OFF SHALL force IDLE next cycle, o_led=0, no o_done pulse.
REQ-022 i_stop and i_start together in IDLE: stop wins, stay IDLE.
REQ-023 i_start in the DONE cycle SHALL be ignored; new start accepted from IDLE.
REQ-024 Remaining-pair counter SHALL be REP_LENGTH wide, never wrap below 1.

Reset
REQ-025 i_rst=1 SHALL, at the next edge, force IDLE, o_led=0, o_busy=0, o_done=0, timer count 0, latched config 0.
REQ-026 Reset SHALL take priority over i_start, i_stop and any timeout, including mid-sequence.

Structure
REQ-027 Package blink_pkg SHALL hold the state enum (IDLE, ON, OFF, DONE) and default width constants.
REQ-028 One sub-module blink_timer SHALL be instantiated: synchronous loadable down counter (i_clk, i_rst, i_load, i_val, o_timeout) asserting o_timeout in the cycle its count reaches 1 after load of V (V cycles per phase).
REQ-029 Timer SHALL be the only duration counter; FSM SHALL not count cycles itself.

Verification
REQ-030 on=3, off=2, repeat=2, start pulse -> o_led pattern 1,1,1,0,0,1,1,1,0,0 then o_done one cycle, o_busy high 10 cycles.
REQ-031 on=0, off=0, repeat=0 -> one ON cycle, one OFF cycle, o_done pulse.
REQ-032 on=5, off=5, repeat=3, i_stop at 2nd ON cycle 3 -> IDLE next cycle, o_led=0, no o_done.
REQ-033 Second i_start mid-sequence with on=1 -> ignored, original on=4 timing preserved.
REQ-034 i_rst asserted during OFF of repeat=4 run -> all outputs 0 next edge; fresh start then runs full 4 pairs.
REQ-035 i_start and i_stop together in IDLE -> o_busy stays 0, no activity.
